// File: rtl/hamming_decoder.sv
// hamming_decoder: 12-data/4-check Hamming receive decoder with a two-stage valid/ready pipeline.
// Error counters are compiled only when HAMMING_ERR_CNT_EN is defined.
module hamming_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:1] in_data,
    input  logic [4:1]  in_check,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:1] out_data,
    output logic [4:1]  out_syndrome,
    output logic        out_corrected,
    output logic        out_uncorrectable,
    input  logic        err_clr,
    output logic [15:0] corr_cnt,
    output logic [15:0] uncorr_cnt
);

    function automatic logic [4:1] calc_check(input logic [12:1] d);
        logic [4:1] r;
        r[1] = d[1] ^ d[3] ^ d[5] ^ d[7] ^ d[9]  ^ d[11];
        r[2] = d[2] ^ d[3] ^ d[6] ^ d[7] ^ d[10] ^ d[11];
        r[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[12];
        r[4] = d[8] ^ d[9] ^ d[10] ^ d[11] ^ d[12];
        return r;
    endfunction

    // Syndromes 13..15 match no position, so the word passes through untouched.
    function automatic logic [12:1] fix_data(input logic [12:1] d, input logic [4:1] s);
        logic [12:1] f;
        for (int i = 1; i <= 12; i++) begin
            if (s == 4'(i)) begin
                f[i] = ~d[i];
            end else begin
                f[i] = d[i];
            end
        end
        return f;
    endfunction

    logic        s1_valid;
    logic [12:1] s1_data;
    logic [4:1]  s1_syn;
    logic        load2;
    logic        in_fire;
    logic [4:1]  in_syn;
    logic        s1_corr;
    logic        s1_unc;

    assign in_syn  = calc_check(in_data) ^ in_check;
    assign load2   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || load2;
    assign in_fire = in_valid && in_ready;
    assign s1_corr = (s1_syn != 4'd0) && (s1_syn <= 4'd12);
    assign s1_unc  = (s1_syn >= 4'd13);

    // Stage 1: capture the received word and its syndrome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= 12'd0;
            s1_syn   <= 4'd0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_syn   <= in_syn;
        end else if (load2) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s1_valid;
        end
    end

    // Stage 2: corrected data and flags; fields hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_data          <= 12'd0;
            out_syndrome      <= 4'd0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (load2) begin
            out_valid         <= 1'b1;
            out_data          <= fix_data(s1_data, s1_syn);
            out_syndrome      <= s1_syn;
            out_corrected     <= s1_corr;
            out_uncorrectable <= s1_unc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= 16'd0;
            uncorr_cnt <= 16'd0;
        end else if (err_clr) begin
            corr_cnt   <= 16'd0;
            uncorr_cnt <= 16'd0;
        end else begin
            if (out_fire && out_corrected && (corr_cnt != 16'hFFFF)) begin
                corr_cnt <= corr_cnt + 16'd1;
            end else begin
                corr_cnt <= corr_cnt;
            end
            if (out_fire && out_uncorrectable && (uncorr_cnt != 16'hFFFF)) begin
                uncorr_cnt <= uncorr_cnt + 16'd1;
            end else begin
                uncorr_cnt <= uncorr_cnt;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign corr_cnt       = 16'd0;
    assign uncorr_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: randomized and directed self-checking bench for hamming_decoder
// against a queue-based reference model.
module tb_hamming_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:1] in_data;
    logic [4:1]  in_check;
    logic        out_valid;
    logic        out_ready;
    logic [12:1] out_data;
    logic [4:1]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic        err_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    hamming_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_check(in_check),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_corrected(out_corrected),
        .out_uncorrectable(out_uncorrectable),
        .err_clr(err_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [12:1] data;
        logic [4:1]  syn;
        logic        corr;
        logic        unc;
    } exp_t;

    exp_t        q[$];
    int          total;
    int          bad;
    int          corr_m;
    int          unc_m;
    int          raw_corr;
    logic        hold_pend;
    logic [17:0] held;

    // Each data bit D[i] feeds exactly the check bits named by the binary digits of i.
    function automatic logic [4:1] clean_check(input logic [12:1] d);
        logic [4:1] s;
        s = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            if (d[i]) s = s ^ 4'(i);
        end
        return s;
    endfunction

    function automatic exp_t ref_decode(input logic [12:1] d, input logic [4:1] c);
        exp_t e;
        int   s;
        s = int'(c ^ clean_check(d));
        e.syn  = 4'(s);
        e.corr = (s >= 1) && (s <= 12);
        e.unc  = (s >= 13);
        e.data = e.corr ? (d ^ (12'd1 << (s - 1))) : d;
        return e;
    endfunction

    function automatic logic [15:0] exp_cnt(input int v);
        return CNT_EN ? 16'(v) : 16'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check handshakes against the model, advance, check counters.
    task automatic cycle(input logic v, input logic [12:1] d, input logic [4:1] c,
                         input logic ordy, input logic clr, output logic acc);
        logic        in_fire;
        logic        out_fire;
        logic        fired_corr;
        logic        fired_unc;
        logic [17:0] obs;
        in_valid  = v;
        in_data   = d;
        in_check  = c;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        obs = {out_data, out_syndrome, out_corrected, out_uncorrectable};
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
        if (hold_pend) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_fields", 32'(obs), 32'(held));
        end
        in_fire    = v && in_ready;
        out_fire   = out_valid && ordy;
        fired_corr = 1'b0;
        fired_unc  = 1'b0;
        if (out_fire) begin
            chk("out_present", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("out_word", 32'(obs), 32'(q[0]));
                fired_corr = q[0].corr;
                fired_unc  = q[0].unc;
                void'(q.pop_front());
            end
        end
        hold_pend = out_valid && !ordy;
        held      = obs;
        if (in_fire) q.push_back(ref_decode(d, c));
        @(posedge clk);
        if (fired_corr) raw_corr++;
        if (clr) begin
            corr_m = 0;
            unc_m  = 0;
        end else begin
            if (fired_corr && corr_m < 65535) corr_m++;
            if (fired_unc && unc_m < 65535) unc_m++;
        end
        @(negedge clk);
        chk("corr_cnt", 32'(corr_cnt), 32'(exp_cnt(corr_m)));
        chk("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_cnt(unc_m)));
        acc = in_fire;
    endtask

    task automatic send(input logic [12:1] d, input logic [4:1] c, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, d, c, ordy, 1'b0, acc);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 12'd0, 4'd0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() != 0; k++) idle(1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic send_corr(input logic ordy);
        logic [12:1] d;
        int          b;
        d = 12'($urandom);
        b = $urandom_range(0, 11);
        send(d ^ (12'd1 << b), clean_check(d), ordy);
    endtask

    initial begin : stim
        logic        acc;
        logic [12:1] wd[4];
        logic [4:1]  wc[4];
        int          idx;
        int          n;
        logic [12:1] d;
        logic [4:1]  c;
        total = 0; bad = 0; corr_m = 0; unc_m = 0; raw_corr = 0;
        hold_pend = 1'b0; held = 18'd0;
        rst = 1'b1; in_valid = 1'b0; in_data = 12'd0; in_check = 4'd0;
        out_ready = 1'b0; err_clr = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_syn", 32'(out_syndrome), 32'd0);
        chk("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean word with latency check
        cycle(1'b1, 12'hA5C, 4'h3, 1'b1, 1'b0, acc);
        chk("clean_acc", 32'(acc), 32'd1);
        chk("lat_n", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("lat_n1", 32'(out_valid), 32'd1);
        chk("clean_data", 32'(out_data), 32'h0A5C);
        chk("clean_syn", 32'(out_syndrome), 32'd0);
        chk("clean_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
        idle(1'b1);

        // Single data error (D6)
        send(12'hA7C, 4'h3, 1'b1);
        idle(1'b1);
        chk("sec_data", 32'(out_data), 32'h0A5C);
        chk("sec_syn", 32'(out_syndrome), 32'd6);
        chk("sec_flags", 32'({out_corrected, out_uncorrectable}), 32'b10);
        idle(1'b1);
        chk("sec_cnt", 32'(corr_cnt), 32'(exp_cnt(1)));

        // Uncorrectable (D12 and D1 flipped)
        send(12'h25D, 4'h3, 1'b1);
        idle(1'b1);
        chk("unc_data", 32'(out_data), 32'h025D);
        chk("unc_syn", 32'(out_syndrome), 32'd13);
        chk("unc_flags", 32'({out_corrected, out_uncorrectable}), 32'b01);
        idle(1'b1);
        chk("unc_cnt", 32'(uncorr_cnt), 32'(exp_cnt(1)));

        // Backpressure: 4 words offered, 5 stalled cycles
        for (int k = 0; k < 4; k++) begin
            wd[k] = 12'($urandom);
            wc[k] = clean_check(wd[k]) ^ 4'($urandom_range(0, 15));
        end
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, wd[idx], wc[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        for (int k = 0; k < 20 && idx < 4; k++) begin
            cycle(1'b1, wd[idx], wc[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd4);
        drain();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            d = 12'($urandom);
            c = clean_check(d);
            case ($urandom_range(0, 3))
                0: c = c;
                1: d = d ^ (12'd1 << $urandom_range(0, 11));
                2: c = c ^ (4'd1 << $urandom_range(0, 3));
                default: c = 4'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, d, c, $urandom_range(0, 3) != 0, 1'b0, acc);
        end
        drain();

        // Drive corrected count to saturation, then one more
        n = 65535 - raw_corr;
        for (int k = 0; k < n; k++) send_corr(1'b1);
        drain();
        chk("sat_reach", 32'(corr_cnt), 32'(exp_cnt(65535)));
        send_corr(1'b1);
        drain();
        chk("sat_hold", 32'(corr_cnt), 32'(exp_cnt(65535)));

        // Reset with two words in flight
        send_corr(1'b0);
        send_corr(1'b0);
        chk("pre_rst_full", 32'(q.size()), 32'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
        q.delete();
        corr_m = 0; unc_m = 0; hold_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(12'hA7C, 4'h3, 1'b1);
        idle(1'b1);
        chk("post_rst_data", 32'(out_data), 32'h0A5C);
        idle(1'b1);
        chk("post_rst_cnt", 32'(corr_cnt), 32'(exp_cnt(1)));

        // err_clr coincident with a corrected handshake
        send_corr(1'b1);
        idle(1'b0);
        chk("clr_pending", 32'(out_corrected & out_valid), 32'd1);
        cycle(1'b0, 12'd0, 4'd0, 1'b1, 1'b1, acc);
        chk("clr_cnt", 32'(corr_cnt), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Receive-side decoder for the team's 12-data/4-check Hamming scheme; inverse of the check-bit generator. Accepts a data word and its four received check bits over a valid/ready handshake. Recomputes the check bits, forms the syndrome and corrects any single-bit data error. Emits the data with status through a two-stage pipeline with full backpressure. Sits between the link/memory read path and the consumer of corrected data.

## Interface
- No parameters; widths are fixed by the code.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  decoder can accept this cycle.
- `in_data`  in  [12:1]  received data bits D.
- `in_check`  in  [4:1]  received check bits C.
- `out_valid`  out  1  decoded word present.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_data`  out  [12:1]  corrected data.
- `out_syndrome`  out  [4:1]  raw syndrome of this word.
- `out_corrected`  out  1  a data bit was flipped.
- `out_uncorrectable`  out  1  syndrome in 13..15; data passed unmodified.
- `err_clr`  in  1  synchronous clear of error counters.
- `corr_cnt`  out  [15:0]  saturating count of corrected words.
- `uncorr_cnt`  out  [15:0]  saturating count of uncorrectable words.

## Operation
- Recomputed checks:
  - R1 = D1^D3^D5^D7^D9^D11.
  - R2 = D2^D3^D6^D7^D10^D11.
  - R3 = D4^D5^D6^D7^D12.
  - R4 = D8^D9^D10^D11^D12.
- Syndrome S[4:1] = R ^ C.
- S = 0: data unchanged; corrected = 0, uncorrectable = 0.
- S in 1..12: flip D[S]; corrected = 1.
- S in 13..15: data unchanged; uncorrectable = 1.
- Single check-bit errors alias with data errors and are corrected as such: C1/C2/C3/C4 alias D1/D2/D4/D8 (S = 1/2/4/8). This is accepted behaviour. Double errors may miscorrect, which is also accepted.
- Stage 1 registers in_data, in_check and S. Stage 2 registers the corrected data and flags.
- Stage 2 loads when s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || stage-2 load condition. in_ready is combinational from out_ready.
- A word is transferred on any edge where valid && ready. Output fields hold stable while out_valid && !out_ready.
- Counters increment on the output handshake according to that word's flags.
- Counters saturate at 16'hFFFF.
- err_clr has priority over a same-cycle increment.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_syndrome = 0, out_corrected = 0, out_uncorrectable = 0, corr_cnt = 0, uncorr_cnt = 0. Both pipeline valids are 0.
- Latency: a word accepted on edge N presents out_valid from edge N+1, if not blocked.
- Throughput: one word per cycle while out_ready = 1.
- Stall: with out_ready = 0, the pipeline holds at most 2 words. in_ready falls when both stages are full and rises in the same cycle out_ready returns.
- Simultaneous in and out handshakes on a full pipeline: both complete; no bubble and no loss.
- Reset mid-operation drops in-flight words immediately and clears the counters.

## Configuration
- `HAMMING_ERR_CNT_EN` defined: err_clr, corr_cnt and uncorr_cnt behave as specified.
- `HAMMING_ERR_CNT_EN` undefined: the counter logic is not compiled. The ports remain; corr_cnt and uncorr_cnt are tied to 0 and err_clr is ignored. Datapath behaviour is identical in both builds.

## Test plan
- Clean word: D = 12'hA5C, C = 4'h3, out_ready = 1. Expect on the next-but-one edge: out_data = A5C, S = 0, both flags 0.
- Single data error: D = 12'hA7C (D6 flipped), C = 4'h3. Expect out_data = A5C, S = 6, corrected = 1, corr_cnt +1.
- Uncorrectable: D = 12'h25D (D12 and D1 flipped), C = 4'h3. Expect S = 13, out_data = 25D, uncorrectable = 1, uncorr_cnt +1.
- Backpressure: stream 4 words back to back with out_ready = 0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - Outputs hold stable while stalled.
  - All 4 words emerge in order after release.
- Counter edges:
  - Preload corr_cnt to FFFF via 65535 corrected words; one more keeps it at FFFF.
  - Assert err_clr coincident with a corrected handshake: corr_cnt = 0 afterwards.
- Reset mid-stream: assert rst with 2 words in flight. Expect out_valid = 0 and in_ready = 1 immediately, and counters = 0. The next word decodes normally.
